// File: rtl/sfq_gate_pkg.sv
// Shared types and the gate truth-function for the clocked RSFQ gate array.
package sfq_gate_pkg;

  // Gate function selected at run time; the encoding matches the mode input.
  typedef enum logic [2:0] {
    MODE_XNOR = 3'd0,
    MODE_XOR  = 3'd1,
    MODE_AND  = 3'd2,
    MODE_OR   = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_NAND = 3'd5,
    MODE_NOTA = 3'd6,
    MODE_DFFA = 3'd7
  } gate_mode_e;

  // Channel arrival state: bit 0 = A seen, bit 1 = B seen.
  typedef enum logic [1:0] {
    S0  = 2'b00,
    SA  = 2'b01,
    SB  = 2'b10,
    SAB = 2'b11
  } chan_state_e;

  // Evaluate the selected two-input function on the stored arrival flags.
  function automatic logic eval_gate(gate_mode_e mode, logic fa, logic fb);
    logic f;
    case (mode)
      MODE_XNOR: f = ~(fa ^ fb);
      MODE_XOR:  f = fa ^ fb;
      MODE_AND:  f = fa & fb;
      MODE_OR:   f = fa | fb;
      MODE_NOR:  f = ~(fa | fb);
      MODE_NAND: f = ~(fa & fb);
      MODE_NOTA: f = ~fa;
      MODE_DFFA: f = fa;
      default:   f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sfq_gate_channel.sv
// One clocked RSFQ gate channel: edge-encoded pulse detection, saturating
// A/B arrival state, hold-window checker, LAT-deep output pipe, toggle output.
module sfq_gate_channel
  import sfq_gate_pkg::*;
#(
  parameter int LAT      = 2,
  parameter int HOLD_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       sclk,
  input  logic       viol_clr,
  output logic       q,
  output logic       viol
);

  localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

  logic           a_prev_q, b_prev_q, s_prev_q;
  chan_state_e    state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [LAT-1:0] pipe_q, pipe_d;
  logic           q_q, q_d;
  logic           viol_q, viol_d;

  logic a_pulse, b_pulse, s_pulse;
  logic fa, fb, f, na, nb, hit;

  // Next-state logic: pulse detect, gate evaluation, state update, hold check.
  always_comb begin
    a_pulse = en & (a ^ a_prev_q);
    b_pulse = en & (b ^ b_prev_q);
    s_pulse = en & (sclk ^ s_prev_q);

    fa = (state_q == SA) || (state_q == SAB);
    fb = (state_q == SB) || (state_q == SAB);
    f  = eval_gate(gate_mode_e'(mode), fa, fb);

    // The clock consumes the old state; same-edge arrivals land in the cleared state.
    na = (s_pulse ? 1'b0 : fa) | a_pulse;
    nb = (s_pulse ? 1'b0 : fb) | b_pulse;
    state_d = chan_state_e'({nb, na});

    hold_d = hold_q;
    if (s_pulse) begin
      hold_d = HW'(HOLD_CYC);
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end

    hit    = (a_pulse | b_pulse) & (s_pulse | (hold_q != '0));
    viol_d = (viol_q & ~viol_clr) | hit;

    pipe_d    = '0;
    pipe_d[0] = s_pulse & f;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    q_d = q_q ^ pipe_q[LAT-1];
  end

  // State registers; reset captures current input levels to avoid false pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_prev_q <= a;
      b_prev_q <= b;
      s_prev_q <= sclk;
      state_q  <= S0;
      hold_q   <= '0;
      pipe_q   <= '0;
      q_q      <= 1'b0;
      viol_q   <= 1'b0;
    end else begin
      a_prev_q <= a;
      b_prev_q <= b;
      s_prev_q <= sclk;
      state_q  <= state_d;
      hold_q   <= hold_d;
      pipe_q   <= pipe_d;
      q_q      <= q_d;
      viol_q   <= viol_d;
    end
  end

  assign q    = q_q;
  assign viol = viol_q;

endmodule

// File: rtl/sfq_clocked_gate_array.sv
// Array of CH independent clocked RSFQ gate channels sharing a mode select
// and a begin-period counter that gates pulse acceptance after reset.
module sfq_clocked_gate_array
  import sfq_gate_pkg::*;
#(
  parameter int CH        = 4,
  parameter int LAT       = 2,
  parameter int HOLD_CYC  = 3,
  parameter int BEGIN_CYC = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    mode,
  input  logic [CH-1:0] a,
  input  logic [CH-1:0] b,
  input  logic [CH-1:0] sclk,
  input  logic          viol_clr,
  output logic [CH-1:0] q,
  output logic [CH-1:0] viol,
  output logic          ready
);

  localparam int BW = (BEGIN_CYC > 0) ? $clog2(BEGIN_CYC + 1) : 1;

  logic [BW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;

  // Count begin-period edges; ready rises BEGIN_CYC edges after the first live edge.
  always_comb begin
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (!ready_q) begin
      if (cnt_q == BW'(BEGIN_CYC)) begin
        ready_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Begin counter and ready register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      sfq_gate_channel #(
        .LAT      (LAT),
        .HOLD_CYC (HOLD_CYC)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .en       (ready_q),
        .mode     (mode),
        .a        (a[gi]),
        .b        (b[gi]),
        .sclk     (sclk[gi]),
        .viol_clr (viol_clr),
        .q        (q[gi]),
        .viol     (viol[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sfq_clocked_gate_array.sv
// Self-checking bench: table of single-evaluation vectors plus hand-written
// hold, same-edge, begin-period and mid-flight reset sequences. Expected q
// vectors are queued when sclk is driven and compared when they are due.
module tb_sfq_clocked_gate_array;

  localparam int CH    = 4;
  localparam int LAT   = 2;
  localparam int HOLD  = 3;
  localparam int BEGIN = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    mode = 3'd0;
  logic [CH-1:0] a = '0, b = '0, sclk = '0;
  logic          viol_clr = 1'b0;
  logic [CH-1:0] q, viol;
  logic          ready;

  sfq_clocked_gate_array #(
    .CH(CH), .LAT(LAT), .HOLD_CYC(HOLD), .BEGIN_CYC(BEGIN)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .a(a), .b(b), .sclk(sclk),
    .viol_clr(viol_clr), .q(q), .viol(viol), .ready(ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            cyc;
    logic [CH-1:0] exp;
  } sb_t;
  sb_t sb[$];
  logic [CH-1:0] exp_q = '0;

  typedef struct {
    int ch;
    int md;
    int na;
    int nb;
    bit bfirst;
    bit tog;
  } vec_t;
  vec_t vt[17];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare queued q expectations on the falling edge once they are due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      chk($sformatf("q_at_%0d", sb[0].cyc), 32'(q), 32'(sb[0].exp));
      void'(sb.pop_front());
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive an sclk pulse; q must hold for LAT-1 more edges after detection, then toggle if tog.
  task automatic fire_sclk(int ch, bit tog);
    sb_t e;
    sclk[ch] = ~sclk[ch];
    e.cyc = cyc + LAT;
    e.exp = exp_q;
    sb.push_back(e);
    if (tog) exp_q[ch] = ~exp_q[ch];
    e.cyc = cyc + LAT + 1;
    e.exp = exp_q;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Release reset and check ready rises exactly BEGIN_CYC edges after the first live edge.
  task automatic release_rst(bit toggle_inputs);
    rst = 1'b0;
    for (int i = 1; i <= BEGIN + 1; i++) begin
      if (toggle_inputs && i <= 6) begin
        a = ~a; b = ~b; sclk = ~sclk;
      end
      tick();
      chk($sformatf("ready_e%0d", i), 32'(ready), 32'(i > BEGIN));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{0, 0, 0, 0, 0, 1};
    vt[1]  = '{0, 0, 1, 1, 0, 1};
    vt[2]  = '{0, 0, 1, 0, 0, 0};
    vt[3]  = '{1, 1, 2, 0, 0, 1};
    vt[4]  = '{1, 1, 1, 1, 1, 0};
    vt[5]  = '{3, 2, 1, 1, 0, 1};
    vt[6]  = '{3, 2, 0, 1, 0, 0};
    vt[7]  = '{3, 3, 0, 1, 0, 1};
    vt[8]  = '{3, 3, 0, 0, 0, 0};
    vt[9]  = '{0, 4, 0, 0, 0, 1};
    vt[10] = '{0, 4, 1, 0, 0, 0};
    vt[11] = '{1, 5, 1, 1, 0, 0};
    vt[12] = '{1, 5, 0, 2, 0, 1};
    vt[13] = '{2, 6, 0, 1, 0, 1};
    vt[14] = '{2, 6, 1, 1, 0, 0};
    vt[15] = '{2, 7, 1, 0, 0, 1};
    vt[16] = '{2, 7, 0, 1, 0, 0};

    // Reset state, inputs toggled while in reset, pulses during begin period.
    tick(3);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_viol", 32'(viol), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    a = ~a; b = ~b; sclk = ~sclk;
    tick();
    release_rst(1'b1);
    tick(LAT + 2);
    chk("begin_q", 32'(q), 32'd0);
    chk("begin_viol", 32'(viol), 32'd0);
    $display("begin period: ready at edge %0d after release", BEGIN + 1);

    // Table-driven single evaluations.
    for (int i = 0; i < 17; i++) begin
      mode = 3'(vt[i].md);
      if (vt[i].bfirst) begin
        for (int k = 0; k < vt[i].nb; k++) begin b[vt[i].ch] = ~b[vt[i].ch]; tick(2); end
        for (int k = 0; k < vt[i].na; k++) begin a[vt[i].ch] = ~a[vt[i].ch]; tick(2); end
      end else begin
        for (int k = 0; k < vt[i].na; k++) begin a[vt[i].ch] = ~a[vt[i].ch]; tick(2); end
        for (int k = 0; k < vt[i].nb; k++) begin b[vt[i].ch] = ~b[vt[i].ch]; tick(2); end
      end
      fire_sclk(vt[i].ch, vt[i].tog);
      tick(6);
      chk($sformatf("viol_vec%0d", i), 32'(viol), 32'd0);
      $display("vec %0d: ch=%0d mode=%0d na=%0d nb=%0d bfirst=%0d toggle=%0d",
               i, vt[i].ch, vt[i].md, vt[i].na, vt[i].nb, vt[i].bfirst, vt[i].tog);
    end
    drain();

    // Hold window on ch2: A at k+d after sclk at k; A must still be counted.
    mode = 3'd2;
    for (int d = 2; d <= 4; d++) begin
      viol_clr = 1'b1; tick(); viol_clr = 1'b0;
      chk($sformatf("viol_clr_d%0d", d), 32'(viol), 32'd0);
      fire_sclk(2, 1'b0);
      tick(d);
      a[2] = ~a[2];
      tick();
      chk($sformatf("hold_viol_d%0d", d), 32'(viol[2]), 32'(d <= HOLD));
      tick(5);
      b[2] = ~b[2];
      tick(5);
      fire_sclk(2, 1'b1);
      tick(6);
      $display("hold: ch2 A at sclk+%0d viol=%0b", d, viol[2]);
    end

    // Violation on the same edge as viol_clr keeps the bit set.
    viol_clr = 1'b1; tick(); viol_clr = 1'b0;
    fire_sclk(2, 1'b0);
    tick();
    a[2] = ~a[2]; viol_clr = 1'b1;
    tick();
    viol_clr = 1'b0;
    chk("viol_clr_vs_hit", 32'(viol[2]), 32'd1);
    tick(5);
    fire_sclk(2, 1'b0);
    tick(6);
    viol_clr = 1'b1; tick(); viol_clr = 1'b0;
    $display("viol_clr collision: ch2 viol=%0b", viol[2]);

    // Same-edge A and sclk, DFF mode on ch1.
    mode = 3'd7;
    a[1] = ~a[1];
    fire_sclk(1, 1'b0);
    tick();
    chk("same_edge_viol", 32'(viol), 32'h2);
    tick(5);
    fire_sclk(1, 1'b1);
    tick(6);
    chk("same_edge_viol_sticky", 32'(viol[1]), 32'd1);
    viol_clr = 1'b1; tick(); viol_clr = 1'b0;
    chk("same_edge_cleared", 32'(viol), 32'd0);
    $display("same-edge: ch1 A+sclk then sclk");
    drain();

    // Reset while a toggle is in the pipe.
    mode = 3'd4;
    sclk[0] = ~sclk[0];
    tick();
    rst = 1'b1;
    exp_q = '0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      chk($sformatf("midrst_q%0d", i), 32'(q), 32'd0);
      chk($sformatf("midrst_ready%0d", i), 32'(ready), 32'd0);
    end
    release_rst(1'b0);
    tick(LAT + 2);
    chk("midrst_flushed_q", 32'(q), 32'd0);
    mode = 3'd0;
    fire_sclk(3, 1'b1);
    tick(6);
    drain();
    $display("mid-flight reset: q=%0h ready=%0b", q, ready);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
